// File: rtl/hamming_dec_rx_if.sv
// -----------------------------------------------------------------------------
// hamming_dec_rx_if
// Bundles the serial receive inputs and the decoded/serial outputs of the
// Hamming(15,11) receiver.
//   sl_in      : serial codeword bit, taken when shift=1
//   shift      : bit strobe, one codeword bit per cycle with shift=1
//   frame_rst  : synchronous restart of the word being collected
//   data_par   : corrected 11-bit data word, held until the next decode
//   dout_valid : one-cycle pulse marking an update of data_par/syndrome/err_flag
//   syndrome   : syndrome of the last decoded word
//   err_flag   : last word had a non-zero syndrome
//   err_cnt    : saturating count of corrected words
//   data_out   : serial corrected data, d0 first (0 when so_valid=0)
//   so_valid   : data_out carries a valid data bit
//   busy       : a word is partially collected or being decoded
// master drives the receive inputs; slave is the decoder.
// -----------------------------------------------------------------------------
interface hamming_dec_rx_if;
    logic        sl_in;
    logic        shift;
    logic        frame_rst;
    logic [10:0] data_par;
    logic        dout_valid;
    logic [3:0]  syndrome;
    logic        err_flag;
    logic [7:0]  err_cnt;
    logic        data_out;
    logic        so_valid;
    logic        busy;

    modport master (
        output sl_in, shift, frame_rst,
        input  data_par, dout_valid, syndrome, err_flag, err_cnt,
        input  data_out, so_valid, busy
    );

    modport slave (
        input  sl_in, shift, frame_rst,
        output data_par, dout_valid, syndrome, err_flag, err_cnt,
        output data_out, so_valid, busy
    );
endinterface

// File: rtl/hamming_dec_rx.sv
// -----------------------------------------------------------------------------
// hamming_dec_rx
// Serial Hamming(15,11) receiver with single-error correction and serial
// re-transmission of the corrected data bits.
// Ports:
//   clk  : sole clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : hamming_dec_rx_if.slave (serial inputs, decoded and serial outputs)
// A word is collected LSB first (first bit = Hamming position 1). After the
// 15th bit the receiver spends one DECODE cycle; the edge that ends DECODE
// registers data_par/syndrome/err_flag/err_cnt and raises dout_valid. The next
// edge starts an 11-cycle serialisation of d0..d10 on data_out.
// -----------------------------------------------------------------------------
module hamming_dec_rx (
    input  logic              clk,
    input  logic              RST,
    hamming_dec_rx_if.slave   bus
);
    typedef enum logic {COLLECT, DECODE} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    rx_state_t   rx_state_q;
    tx_state_t   tx_state_q;
    logic [3:0]  cnt_q;
    logic [14:0] cw_q;
    logic [10:0] data_par_q;
    logic [3:0]  syn_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;
    logic        dout_valid_q;
    logic [3:0]  tx_idx_q;
    logic        data_out_q;
    logic        so_valid_q;

    logic [3:0]  syn_d;
    logic [14:0] cw_fix_d;
    logic [10:0] data_d;

    // Syndrome is the XOR of the positions of all set bits; a non-zero value
    // names the position to flip. Double errors are miscorrected by design.
    always_comb begin
        syn_d    = '0;
        cw_fix_d = cw_q;
        for (int i = 0; i < 15; i++) begin
            if (cw_q[i]) syn_d = syn_d ^ 4'(i + 1);
        end
        for (int i = 0; i < 15; i++) begin
            if (syn_d == 4'(i + 1)) cw_fix_d[i] = ~cw_q[i];
        end
        // Data lives at positions 3,5,6,7,9..15 (indices 2,4,5,6,8..14).
        data_d = {cw_fix_d[14:8], cw_fix_d[6:4], cw_fix_d[2]};
    end

    // Receive FSM: collect 15 bits, then one DECODE cycle. A shift during
    // DECODE is already bit 0 of the next word, so words may run back to back.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rx_state_q   <= COLLECT;
            cnt_q        <= '0;
            cw_q         <= '0;
            data_par_q   <= '0;
            syn_q        <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            // frame_rst does not cancel a decode already in progress.
            if (rx_state_q == DECODE) begin
                data_par_q   <= data_d;
                syn_q        <= syn_d;
                err_q        <= (syn_d != 4'd0);
                dout_valid_q <= 1'b1;
                if (syn_d != 4'd0 && err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            if (bus.frame_rst) begin
                cnt_q      <= '0;
                rx_state_q <= COLLECT;
            end else begin
                rx_state_q <= COLLECT;
                if (bus.shift) begin
                    cw_q[cnt_q] <= bus.sl_in;
                    if (cnt_q == 4'd14) begin
                        cnt_q      <= '0;
                        rx_state_q <= DECODE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            end
        end
    end

    // Serial TX FSM: a dout_valid always (re)starts from d0 of the new word.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= '0;
            data_out_q <= 1'b0;
            so_valid_q <= 1'b0;
        end else if (dout_valid_q) begin
            tx_state_q <= TX_SHIFT;
            tx_idx_q   <= 4'd1;
            data_out_q <= data_par_q[0];
            so_valid_q <= 1'b1;
        end else if (tx_state_q == TX_SHIFT) begin
            if (tx_idx_q == 4'd11) begin
                tx_state_q <= TX_IDLE;
                tx_idx_q   <= '0;
                data_out_q <= 1'b0;
                so_valid_q <= 1'b0;
            end else begin
                data_out_q <= data_par_q[tx_idx_q];
                tx_idx_q   <= tx_idx_q + 4'd1;
            end
        end
    end

    assign bus.data_par   = data_par_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.syndrome   = syn_q;
    assign bus.err_flag   = err_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.data_out   = data_out_q;
    assign bus.so_valid   = so_valid_q;
    assign bus.busy       = (cnt_q != 4'd0) || (rx_state_q == DECODE);
endmodule

// File: doc/hamming_dec_rx.md
HAMMING_DEC_RX -- requirements
Module: hamming_dec_rx

Interface
REQ-001 Parameters: none; codeword length fixed at 15, data length fixed at 11.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 sl_in  input  1  serial codeword bit; sampled only when shift=1.
REQ-005 shift  input  1  bit strobe; one codeword bit accepted per cycle with shift=1.
REQ-006 frame_rst  input  1  synchronous frame restart; discards the partial word in progress.
REQ-007 data_par  output  11  corrected data word, registered, held until next decode.
REQ-008 dout_valid  output  1  one-cycle pulse; data_par, syndrome and err_flag are updated this cycle.
REQ-009 syndrome  output  4  syndrome of last decoded word.
REQ-010 err_flag  output  1  1 when the last word had non-zero syndrome.
REQ-011 err_cnt  output  8  count of corrected words, saturating at 255.
REQ-012 data_out  output  1  serial corrected data, d0 first.
REQ-013 so_valid  output  1  high while data_out carries a valid data bit.
REQ-014 busy  output  1  high when the bit counter is non-zero or the FSM is in DECODE.

Function
REQ-015 Bit order: the first accepted bit is codeword[0], i.e. Hamming position 1; bit i is position i+1.
REQ-016 Parity bits are at positions 1, 2, 4 and 8.
REQ-017 Data mapping: d0..d10 occupy positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14 and 15 in ascending order.
REQ-018 Receive FSM states: COLLECT and DECODE; reset enters COLLECT with bit counter 0.
REQ-019 COLLECT: on shift=1, sl_in is stored at codeword[cnt] and cnt increments.
REQ-020 COLLECT -> DECODE: on shift=1 with cnt=14; cnt wraps to 0.
REQ-021 DECODE lasts exactly 1 cycle, then returns to COLLECT.
REQ-022 shift=1 during DECODE is accepted as bit 0 of the next word, so back-to-back words need no gap.
REQ-023 syndrome = XOR of (i+1) over all i where codeword[i]=1.
REQ-024 syndrome=0: no correction.
REQ-025 syndrome=s with s in 1..15: codeword bit s-1 is inverted before data extraction.
REQ-026 Double errors are not detected; they are miscorrected by design.
REQ-027 Latency: dout_valid pulses in the cycle after the 15th accepted bit (the DECODE cycle registers outputs); data_par, syndrome and err_flag update together with it.
REQ-028 err_cnt increments on every dout_valid with err_flag=1, and holds at 255.
REQ-029 Serial TX FSM states: TX_IDLE and TX_SHIFT.
REQ-030 TX_IDLE -> TX_SHIFT: in the cycle after dout_valid.
REQ-031 TX_SHIFT: d0..d10 are driven on data_out over 11 consecutive cycles with so_valid=1, then the FSM returns to TX_IDLE.
REQ-032 data_out = 0 whenever so_valid = 0.
REQ-033 A new dout_valid during TX_SHIFT restarts serialisation from d0 of the new word; this is unreachable at full rate (15 > 12).
REQ-034 frame_rst=1: cnt is forced to 0 and the FSM to COLLECT, and shift is ignored that cycle.
REQ-035 frame_rst does not affect data_par, err_cnt or the TX FSM.
REQ-036 frame_rst in the DECODE cycle still completes that decode.

Reset
REQ-037 RST low asynchronously clears cnt, codeword, data_par, syndrome, err_flag, err_cnt, dout_valid, so_valid, data_out and busy to 0, and sets both FSMs to their idle states (COLLECT, TX_IDLE).
REQ-038 RST low mid-word discards that word; no dout_valid is produced for it.
REQ-039 Release of RST takes effect on the next rising clk edge.

Verification
REQ-040 Shift in 0x0000 -> data_par=0x000, syndrome=0, err_flag=0, dout_valid one cycle after 15th bit.
REQ-041 Shift in 0x5A25 -> data_par=0x5A5, syndrome=0, err_cnt=0, data_out serialises 1,0,1,0,0,1,0,1,1,0,1.
REQ-042 Shift in 0x5A65 (position 7 flipped) -> syndrome=7, err_flag=1, data_par=0x5A5, err_cnt=1.
REQ-043 Shift in 0x5AA5 (parity position 8 flipped) -> syndrome=8, data_par=0x5A5, err_cnt increments.
REQ-044 7 bits shifted, then RST low for 1 cycle, then 0x5A25 -> no dout_valid for the partial word; data_par=0x5A5 after the full word; same result with frame_rst replacing RST.
REQ-045 Two words 0x5A25 and 0x5A65 with shift held high for 30 cycles -> two dout_valid pulses 15 cycles apart; err_cnt=1.
